// File: rtl/mipi_csi_rx_packet_decoder_param.sv
// mipi_csi_rx_packet_decoder_param: CSI-2 RX packet decoder for 1..NUM_LANES active byte lanes
// Parses the 4-byte header, flags payload bytes per lane, captures the 16-bit CRC and aborts
// on truncation. All outputs are registered with one cycle of latency.
// Ports: clk_i/reset_i (async active-high); data_valid_i/data_i lane bytes (lane 0 earliest);
// active_lanes_i lane count latched at packet start; packet_header_o/header_valid_o/short_packet_o;
// payload_data_o/payload_valid_o/payload_last_o; received_crc_o/crc_received_valid_o;
// packet_done_o; error_o.
// Optional MIPI_CSI_RX_PD_STATS_EN adds pkt_count_o (wrapping) and err_count_o (saturating).
module mipi_csi_rx_packet_decoder_param #(
  parameter int NUM_LANES = 4,
  parameter int LW = $clog2(NUM_LANES) + 1
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [NUM_LANES-1:0]   data_valid_i,
  input  logic [8*NUM_LANES-1:0] data_i,
  input  logic [LW-1:0]          active_lanes_i,
  output logic [31:0]            packet_header_o,
  output logic                   header_valid_o,
  output logic                   short_packet_o,
  output logic [8*NUM_LANES-1:0] payload_data_o,
  output logic [NUM_LANES-1:0]   payload_valid_o,
  output logic                   payload_last_o,
  output logic [15:0]            received_crc_o,
  output logic                   crc_received_valid_o,
  output logic                   packet_done_o,
  output logic                   error_o
`ifdef MIPI_CSI_RX_PD_STATS_EN
  ,
  output logic [15:0]            pkt_count_o,
  output logic [7:0]             err_count_o
`endif
);
  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, CRC} state_t;
  state_t st, st_n;
  logic [LW-1:0] a_q, a_n;
  logic [16:0] cnt, cnt_n;
  logic [31:0] sh, sh_n, hdr_n;
  logic [15:0] crc_n;
  logic [NUM_LANES-1:0] pv_n;
  logic [7:0] b;
  logic hv_n, sp_n, last_n, cv_n, done_n, err_n;
  // Bytes of a beat are walked in lane order through a byte-level state machine, so a
  // header, payload end and CRC may all share one beat; bytes seen after returning to
  // IDLE within the same beat are dropped.
  always_comb begin
    st_n = st;
    a_n = a_q;
    cnt_n = cnt;
    sh_n = sh;
    hdr_n = packet_header_o;
    crc_n = received_crc_o;
    pv_n = '0;
    b = '0;
    hv_n = 1'b0;
    sp_n = 1'b0;
    last_n = 1'b0;
    cv_n = 1'b0;
    done_n = 1'b0;
    err_n = 1'b0;
    if (st == IDLE && data_valid_i[0]) begin
      st_n = HDR;
      a_n = active_lanes_i;
      cnt_n = 17'd4;
    end else if (st != IDLE && !data_valid_i[0]) begin
      st_n = IDLE;
      err_n = 1'b1;
    end
    for (int k = 0; k < NUM_LANES; k++) begin
      if (k < int'(a_n) && data_valid_i[k]) begin
        b = data_i[8*k +: 8];
        if (st_n == HDR) begin
          sh_n = {sh_n[23:0], b};
          cnt_n = cnt_n - 17'd1;
          if (cnt_n == 17'd0) begin
            hv_n = 1'b1;
            hdr_n = sh_n;
            sp_n = sh_n[29:24] < 6'h10;
            if (sp_n) begin
              done_n = 1'b1;
              st_n = IDLE;
            end else if ({sh_n[15:8], sh_n[23:16]} == 16'd0) begin
              st_n = CRC;
              cnt_n = 17'd2;
            end else begin
              st_n = PAYLOAD;
              cnt_n = {1'b0, sh_n[15:8], sh_n[23:16]};
            end
          end
        end else if (st_n == PAYLOAD) begin
          pv_n[k] = 1'b1;
          cnt_n = cnt_n - 17'd1;
          if (cnt_n == 17'd0) begin
            last_n = 1'b1;
            st_n = CRC;
            cnt_n = 17'd2;
          end
        end else if (st_n == CRC) begin
          if (cnt_n == 17'd2) crc_n[7:0] = b;
          else crc_n[15:8] = b;
          cnt_n = cnt_n - 17'd1;
          if (cnt_n == 17'd0) begin
            cv_n = 1'b1;
            done_n = 1'b1;
            st_n = IDLE;
          end
        end
      end
    end
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      st <= IDLE;
      a_q <= '0;
      cnt <= '0;
      sh <= '0;
      packet_header_o <= '0;
      header_valid_o <= 1'b0;
      short_packet_o <= 1'b0;
      payload_data_o <= '0;
      payload_valid_o <= '0;
      payload_last_o <= 1'b0;
      received_crc_o <= '0;
      crc_received_valid_o <= 1'b0;
      packet_done_o <= 1'b0;
      error_o <= 1'b0;
    end else begin
      st <= st_n;
      a_q <= a_n;
      cnt <= cnt_n;
      sh <= sh_n;
      packet_header_o <= hdr_n;
      header_valid_o <= hv_n;
      short_packet_o <= sp_n;
      payload_data_o <= data_i;
      payload_valid_o <= pv_n;
      payload_last_o <= last_n;
      received_crc_o <= crc_n;
      crc_received_valid_o <= cv_n;
      packet_done_o <= done_n;
      error_o <= err_n;
    end
  end
`ifdef MIPI_CSI_RX_PD_STATS_EN
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pkt_count_o <= '0;
      err_count_o <= '0;
    end else begin
      if (done_n) pkt_count_o <= pkt_count_o + 16'd1;
      if (err_n && err_count_o != 8'hFF) err_count_o <= err_count_o + 8'd1;
    end
  end
`endif
endmodule

// File: tb/tb_mipi_csi_rx_packet_decoder_param.sv
// tb_mipi_csi_rx_packet_decoder_param: directed self-checking bench for the 4-lane decoder
module tb_mipi_csi_rx_packet_decoder_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] valid = '0;
  logic [31:0] data = '0;
  logic [2:0] lanes = 3'd4;
  logic [31:0] header;
  logic hv, sp, last, cv, done, err;
  logic [31:0] pdata;
  logic [3:0] pv;
  logic [15:0] crc;
  int checks = 0;
  int errors = 0;
`ifdef MIPI_CSI_RX_PD_STATS_EN
  logic [15:0] pkt_count;
  logic [7:0] err_count;
`endif
  mipi_csi_rx_packet_decoder_param #(.NUM_LANES(4)) dut (
    .clk_i(clk),
    .reset_i(rst),
    .data_valid_i(valid),
    .data_i(data),
    .active_lanes_i(lanes),
    .packet_header_o(header),
    .header_valid_o(hv),
    .short_packet_o(sp),
    .payload_data_o(pdata),
    .payload_valid_o(pv),
    .payload_last_o(last),
    .received_crc_o(crc),
    .crc_received_valid_o(cv),
    .packet_done_o(done),
    .error_o(err)
`ifdef MIPI_CSI_RX_PD_STATS_EN
    ,
    .pkt_count_o(pkt_count),
    .err_count_o(err_count)
`endif
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] pk(input logic [7:0] b0, b1, b2, b3);
    return {b3, b2, b1, b0};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic [3:0] v, input logic [31:0] d, input logic [2:0] al);
    @(negedge clk);
    valid = v;
    data = d;
    lanes = al;
    @(posedge clk);
    #1;
  endtask
  // Pulse flags packed as {hv, sp, pv[3:0], last, cv, done, err}
  function automatic logic [31:0] flags();
    return {22'd0, hv, sp, pv, last, cv, done, err};
  endfunction
  initial begin
    #12;
    chk("reset_header", header, 32'h0);
    chk("reset_flags", flags(), 32'h0);
    chk("reset_crc", {16'd0, crc}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    // 4 lanes, WC=6
    step(4'b1111, pk(8'h2A, 8'h06, 8'h00, 8'h11), 3'd4);
    chk("t1_header", header, 32'h2A060011);
    chk("t1_hdr_flags", flags(), 32'b10_0000_000_0 << 0 | 32'h200);
    step(4'b1111, pk(8'h01, 8'h02, 8'h03, 8'h04), 3'd4);
    chk("t1_pl1_flags", flags(), {22'd0, 2'b00, 4'b1111, 4'b0000});
    chk("t1_pdata", pdata, 32'h04030201);
    step(4'b1111, pk(8'h05, 8'h06, 8'hAA, 8'hBB), 3'd4);
    chk("t1_pl2_flags", flags(), {22'd0, 2'b00, 4'b0011, 4'b1110});
    chk("t1_crc", {16'd0, crc}, 32'hBBAA);
    step(4'b0000, 32'h0, 3'd4);
    chk("t1_idle_flags", flags(), 32'h0);
    // 1 lane short packet, then back-to-back short packet
    step(4'b0001, pk(8'h00, 8'h0, 8'h0, 8'h0), 3'd1);
    step(4'b0001, pk(8'h05, 8'h0, 8'h0, 8'h0), 3'd1);
    step(4'b0001, pk(8'h00, 8'h0, 8'h0, 8'h0), 3'd1);
    chk("t2_no_hv_yet", flags(), 32'h0);
    step(4'b0001, pk(8'h3F, 8'h0, 8'h0, 8'h0), 3'd1);
    chk("t2_header", header, 32'h0005003F);
    chk("t2_flags", flags(), {22'd0, 2'b11, 4'b0000, 4'b0010});
    step(4'b0001, pk(8'h01, 8'h0, 8'h0, 8'h0), 3'd1);
    step(4'b0001, pk(8'h00, 8'h0, 8'h0, 8'h0), 3'd1);
    step(4'b0001, pk(8'h00, 8'h0, 8'h0, 8'h0), 3'd1);
    step(4'b0001, pk(8'h07, 8'h0, 8'h0, 8'h0), 3'd1);
    chk("t2b_header", header, 32'h01000007);
    chk("t2b_flags", flags(), {22'd0, 2'b11, 4'b0000, 4'b0010});
    // 2 lanes, WC=3
    step(4'b0011, pk(8'h2B, 8'h03, 8'h0, 8'h0), 3'd2);
    chk("t3_mid_hdr", flags(), 32'h0);
    step(4'b0011, pk(8'h00, 8'h22, 8'h0, 8'h0), 3'd2);
    chk("t3_header", header, 32'h2B030022);
    chk("t3_hdr_flags", flags(), {22'd0, 2'b10, 4'b0000, 4'b0000});
    step(4'b0011, pk(8'h01, 8'h02, 8'h0, 8'h0), 3'd2);
    chk("t3_pl1", flags(), {22'd0, 2'b00, 4'b0011, 4'b0000});
    step(4'b0011, pk(8'h03, 8'hCC, 8'h0, 8'h0), 3'd2);
    chk("t3_pl2", flags(), {22'd0, 2'b00, 4'b0001, 4'b1000});
    step(4'b0001, pk(8'hDD, 8'h0, 8'h0, 8'h0), 3'd2);
    chk("t3_crc_flags", flags(), {22'd0, 2'b00, 4'b0000, 4'b0110});
    chk("t3_crc", {16'd0, crc}, 32'hDDCC);
    // 4 lanes, WC=0 long packet
    step(4'b1111, pk(8'h2A, 8'h00, 8'h00, 8'h77), 3'd4);
    chk("t4_hdr_flags", flags(), {22'd0, 2'b10, 4'b0000, 4'b0000});
    step(4'b0011, pk(8'hEE, 8'hFF, 8'h0, 8'h0), 3'd4);
    chk("t4_flags", flags(), {22'd0, 2'b00, 4'b0000, 4'b0110});
    chk("t4_crc", {16'd0, crc}, 32'hFFEE);
    // 4 lanes, WC=8, truncated after first payload beat
    step(4'b1111, pk(8'h2A, 8'h08, 8'h00, 8'h00), 3'd4);
    step(4'b1111, pk(8'h01, 8'h02, 8'h03, 8'h04), 3'd4);
    chk("t5_pl1", flags(), {22'd0, 2'b00, 4'b1111, 4'b0000});
    step(4'b0000, 32'h0, 3'd4);
    chk("t5_abort", flags(), {22'd0, 2'b00, 4'b0000, 4'b0001});
    step(4'b1111, pk(8'h2A, 8'h00, 8'h00, 8'h55), 3'd4);
    chk("t5_next_header", header, 32'h2A000055);
    chk("t5_next_hdr_flags", flags(), {22'd0, 2'b10, 4'b0000, 4'b0000});
`ifdef MIPI_CSI_RX_PD_STATS_EN
    chk("t5_err_count", {24'd0, err_count}, 32'd1);
`endif
    step(4'b0011, pk(8'h12, 8'h34, 8'h0, 8'h0), 3'd4);
    chk("t5_next_flags", flags(), {22'd0, 2'b00, 4'b0000, 4'b0110});
    chk("t5_next_crc", {16'd0, crc}, 32'h3412);
    // Async reset in the middle of a payload
    step(4'b1111, pk(8'h2A, 8'h06, 8'h00, 8'h11), 3'd4);
    step(4'b1111, pk(8'h01, 8'h02, 8'h03, 8'h04), 3'd4);
    rst = 1'b1;
    #1;
    chk("t6_rst_header", header, 32'h0);
    chk("t6_rst_flags", flags(), 32'h0);
    chk("t6_rst_pdata", pdata, 32'h0);
    chk("t6_rst_crc", {16'd0, crc}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    valid = '0;
    step(4'b1111, pk(8'h05, 8'h01, 8'h02, 8'h03), 3'd4);
    chk("t6_header", header, 32'h05010203);
    chk("t6_flags", flags(), {22'd0, 2'b11, 4'b0000, 4'b0010});
    step(4'b0000, 32'h0, 3'd4);
    chk("t6_idle", flags(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mipi_csi_rx_packet_decoder_param.md
Name: mipi_csi_rx_packet_decoder_param

Overview:
- Parametrised successor CSI-2 RX packet decoder. Sits between the lane-merging/deskew stage and the pixel unpacker/CRC checker.
- Takes per-lane byte streams on 1..NUM_LANES active lanes and parses the 4-byte packet header.
- Takes payload length from the header word count; no configuration input supplies it.
- Classifies short and long packets, marks payload bytes per lane, captures the trailing 16-bit CRC and detects truncated packets.

Parameters:
NUM_LANES, 4, physical lane count; legal values 1, 2, 4.
LW, $clog2(NUM_LANES)+1, width of active_lanes_i.

Ports:
clk_i  in  1  clock.
reset_i  in  1  asynchronous active-high reset.
data_valid_i  in  NUM_LANES  per-lane byte valid.
data_i  in  8*NUM_LANES  lane k byte on [8k+7:8k]; lane 0 carries the earliest byte of each beat.
active_lanes_i  in  LW  active lane count: 1, 2 or 4 (values above NUM_LANES are illegal).
packet_header_o  out  32  {DataID, WC lsb, WC msb, ECC}; DataID in [31:24].
header_valid_o  out  1  1-cycle pulse when packet_header_o is updated.
short_packet_o  out  1  qualifies header_valid_o; 1 = DataID[5:0] < 0x10.
payload_data_o  out  8*NUM_LANES  registered copy of data_i.
payload_valid_o  out  NUM_LANES  per-lane flag: byte is payload.
payload_last_o  out  1  beat holds the final payload byte.
received_crc_o  out  16  {crc byte1, crc byte0}.
crc_received_valid_o  out  1  1-cycle pulse when both CRC bytes are captured.
packet_done_o  out  1  1-cycle pulse at packet completion.
error_o  out  1  1-cycle pulse on truncation abort.

Behaviour:
- All outputs are registered. Each output reflects the input beat of the previous cycle (latency 1).
- Reset values: all outputs 0; state IDLE.
- Active lanes: active lanes are 0..A-1, where A is latched from active_lanes_i at start of packet. A changing mid-packet has no effect.
- Beat contract: within a packet every active lane is valid each beat, except the final beat, where lanes 0..k-1 are valid.
- Byte order: bytes are ordered by beat, then by lane index ascending.
- 17-bit byte counter: counts remaining bytes of the current field and is decremented by the number of bytes consumed per beat.
- IDLE:
  - data_valid_i[0]=1 starts a packet.
  - A=4 goes straight to the header-consume path.
  - A<4 enters HDR to collect 4 bytes.
- HDR:
  - After byte 3: pulse header_valid_o; set short_packet_o.
  - WC = {byte2, byte1}.
- After the header:
  - Short packet: pulse packet_done_o; go to IDLE.
  - Long packet, WC=0: go to CRC.
  - Long packet, WC>0: go to PAYLOAD.
- PAYLOAD:
  - payload_valid_o[k]=1 for each byte whose index lies within WC.
  - payload_last_o on the beat holding byte WC-1.
  - Remaining bytes of that beat are CRC bytes.
- CRC:
  - First CRC byte goes to received_crc_o[7:0]; second to [15:8]. They may straddle beats.
  - After the second byte: pulse crc_received_valid_o and packet_done_o in the same cycle; go to IDLE.
  - Valid bytes after the CRC in the same beat are ignored.
- Abort: data_valid_i[0]=0 in HDR/PAYLOAD/CRC:
  - pulse error_o; go to IDLE.
  - No crc_received_valid_o or packet_done_o for that packet.
- Packet turnaround: a new packet may start the cycle after the return to IDLE. No bubble is required beyond the IDLE cycle.
- Async reset mid-packet: immediate return to IDLE; all pulses cleared; partial header discarded.

Optional Feature:
- Macro: MIPI_CSI_RX_PD_STATS_EN.
- When defined, adds pkt_count_o (16-bit, wraps) and err_count_o (8-bit, saturates at 0xFF).
  - pkt_count_o increments on packet_done_o.
  - err_count_o increments on error_o.
  - Both are cleared by reset_i.
- When undefined, neither port exists and no counter logic is built.

Test Plan:
- 4 lanes, beats {2A,06,00,11}, {01,02,03,04}, {05,06,AA,BB}:
  - header 0x2A060011, short=0.
  - payload_valid 1111 then 0011; payload_last on beat 3.
  - received_crc 0xBBAA; crc_valid and done on the same cycle.
- 1 lane, bytes 00,05,00,3F:
  - header_valid after the 4th byte; short=1; packet_done in the same cycle.
  - No payload_valid; next packet starts on the following beat.
- 2 lanes, WC=3, beats {2B,03}, {00,22}, {01,02}, {03,CC}, {DD,-}:
  - payload_valid 11 then 01; payload_last on {03,CC}.
  - crc 0xDDCC on the final beat.
- 4 lanes, WC=0 long packet {2A,00,00,xx}, {EE,FF,-,-}:
  - No payload_valid; crc 0xFFEE; done.
- 4 lanes, WC=8; lane0 valid drops after the first payload beat:
  - error_o pulse; no crc_valid.
  - With STATS_EN: err_count=1. The following clean packet decodes correctly.
- reset_i asserted mid-PAYLOAD:
  - All outputs go to 0 immediately.
  - The next packet header decodes correctly.
